// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - bus widths and field offsets shared by the MEM stage files
package cpu_defs;

  localparam int ES_BUS_W = 175;
  localparam int MS_BUS_W = 169;

  // Field offsets inside the EX-to-MEM bus; [168:0] is the WB layout
  localparam int RES_LSB     = 32;
  localparam int DEST_LSB    = 64;
  localparam int GR_WE_BIT   = 69;
  localparam int EXC_LSB     = 70;
  localparam int EXC_W       = 17;
  localparam int CSR_RD_BIT  = 133;
  localparam int CSR_WE_BIT  = 134;
  localparam int ERTN_BIT    = 135;
  localparam int LD_OP_LSB   = 169;
  localparam int LD_OP_W     = 5;
  localparam int MEM_REQ_BIT = 174;

  // Bit positions inside the one-hot ld_op field {w,hu,h,bu,b}
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef logic [LD_OP_W-1:0] ld_op_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - valid/allowin pipeline handshake carrying a stage bus
interface mem_stage_if #(
  parameter int W = 32
);
  logic         valid;
  logic [W-1:0] bus;
  logic         allowin;

  modport master (output valid, output bus, input allowin);
  modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/halfword and sign/zero extends it
module load_align
  import cpu_defs::*;
(
  input  logic [1:0]  addr_i,
  input  ld_op_t      ld_op_i,
  input  logic [31:0] data_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

    result_o = data_i;
    if (ld_op_i[LD_B])
      result_o = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op_i[LD_BU])
      result_o = {24'd0, byte_sel};
    else if (ld_op_i[LD_H])
      result_o = {{16{half_sel[15]}}, half_sel};
    else if (ld_op_i[LD_HU])
      result_o = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: waits for data-SRAM responses, aligns
// load data, forwards to WB and drops responses of flushed instructions.
module mem_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  es_ms,
  mem_stage_if.master ms_ws,
  input  logic        ws_reflush_ms,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [4:0]  ms_to_ds_dest,
  output logic [31:0] ms_to_ds_value,
  output logic        ms_ld_block,
  output logic        ms_csr,
  output logic        ms_ex
);

  logic                ms_valid_q, ms_valid_d;
  logic [ES_BUS_W-1:0] ms_bus_q;
  logic                data_buf_valid_q, data_buf_valid_d;
  logic [31:0]         data_buf_q;
  logic [1:0]          cancel_cnt_q, cancel_cnt_d;

  logic        mem_req;
  ld_op_t      ld_op;
  logic [31:0] final_result;
  logic [31:0] ld_data;
  logic [31:0] ld_result;
  logic [31:0] ms_result;
  logic        resp_ok;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        handoff;
  logic        buf_capture;
  logic        cancel_inc;
  logic        cancel_dec;

  assign mem_req      = ms_bus_q[MEM_REQ_BIT];
  assign ld_op        = ms_bus_q[LD_OP_LSB +: LD_OP_W];
  assign final_result = ms_bus_q[RES_LSB +: 32];

  // A response only belongs to us once every cancelled response has drained
  assign resp_ok     = data_sram_data_ok & (cancel_cnt_q == 2'd0);
  assign ms_ready_go = !mem_req | data_buf_valid_q | resp_ok;
  assign ms_allowin  = !ms_valid_q | (ms_ready_go & ms_ws.allowin);

  assign es_ms.allowin = ms_allowin;
  assign ms_ws.valid   = ms_valid_q & ms_ready_go & !ws_reflush_ms;
  assign handoff       = ms_ws.valid & ms_ws.allowin;

  assign ld_data = data_buf_valid_q ? data_buf_q : data_sram_rdata;

  load_align u_load_align (
    .addr_i   (final_result[1:0]),
    .ld_op_i  (ld_op),
    .data_i   (ld_data),
    .result_o (ld_result)
  );

  assign ms_result = (|ld_op) ? ld_result : final_result;
  assign ms_ws.bus = {ms_bus_q[MS_BUS_W-1:RES_LSB+32], ms_result, ms_bus_q[RES_LSB-1:0]};

  assign ms_to_ds_dest  = (ms_valid_q & ms_bus_q[GR_WE_BIT]) ? ms_bus_q[DEST_LSB +: 5] : 5'd0;
  assign ms_to_ds_value = ms_result;
  assign ms_ld_block    = ms_valid_q & (|ld_op) & !ms_ready_go;
  assign ms_csr         = ms_valid_q & (ms_bus_q[CSR_WE_BIT] | ms_bus_q[CSR_RD_BIT]);
  assign ms_ex          = ms_valid_q & ((|ms_bus_q[EXC_LSB +: EXC_W]) | ms_bus_q[ERTN_BIT]);

  // Flushing a request whose response is still in flight leaves one stray data_ok
  assign cancel_inc  = ws_reflush_ms & ms_valid_q & mem_req & !data_buf_valid_q & !resp_ok;
  assign cancel_dec  = data_sram_data_ok & (cancel_cnt_q != 2'd0);
  assign buf_capture = resp_ok & ms_valid_q & mem_req & !data_buf_valid_q;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ws_reflush_ms)
      ms_valid_d = 1'b0;
    else if (ms_allowin)
      ms_valid_d = es_ms.valid;

    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc && !cancel_dec && cancel_cnt_q != 2'd3)
      cancel_cnt_d = cancel_cnt_q + 2'd1;
    else if (cancel_dec && !cancel_inc)
      cancel_cnt_d = cancel_cnt_q - 2'd1;

    data_buf_valid_d = data_buf_valid_q;
    if (ws_reflush_ms || handoff)
      data_buf_valid_d = 1'b0;
    else if (buf_capture)
      data_buf_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid_q       <= 1'b0;
      data_buf_valid_q <= 1'b0;
      cancel_cnt_q     <= 2'd0;
    end else begin
      ms_valid_q       <= ms_valid_d;
      data_buf_valid_q <= data_buf_valid_d;
      cancel_cnt_q     <= cancel_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_allowin && es_ms.valid && !ws_reflush_ms)
      ms_bus_q <= es_ms.bus;
    if (buf_capture && !ws_reflush_ms && !handoff)
      data_buf_q <= data_sram_rdata;
  end

  // Three outstanding cancelled responses means EX kept issuing past a flush
  cancel_cnt_sat_a: assert property (@(posedge clk) disable iff (!reset) cancel_cnt_q != 2'd3);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage of the LoongArch core. Sits between the EX stage and WB.
- Accepts the EX-to-MEM bus and waits for the data-SRAM response of any load or store that EX issued.
- Extracts and extends load data, then forwards the 169-bit MEM-to-WB bus to WB.
- Also provides forwarding and hazard information to ID, and discards in-flight responses belonging to flushed instructions.

Parameters:
- ES_BUS_W, 175, width of es_to_ms_bus.
- MS_BUS_W, 169, width of ms_to_ws_bus. Must match the WB field layout.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous reset, active-low. Acts immediately on assertion; released synchronously by the upstream reset generator.
- es_to_ms_valid  in  1  EX holds a valid instruction.
- es_to_ms_bus  in  175  {mem_req[174], ld_op[173:169] one-hot {w,hu,h,bu,b}, then [168:0] in the WB layout with final_result = ALU result/address}.
- ms_allowin  out  1  MEM can accept this cycle.
- ms_to_ws_valid  out  1  valid to WB.
- ms_to_ws_bus  out  169  {rdcntid, vaddr, ertn, csr_we, csr_rd, csr_wmask, csr_num, ex_cause_bus[16:0], gr_we, dest, final_result, pc}.
- ws_allowin  in  1  WB can accept.
- ws_reflush_ms  in  1  flush from WB (exception or ertn).
- data_sram_data_ok  in  1  response strobe; responses return in request order.
- data_sram_rdata  in  32  response data.
- ms_to_ds_dest  out  5  forwarding destination; 0 if no write or not valid.
- ms_to_ds_value  out  32  forwarding value.
- ms_ld_block  out  1  valid load whose data has not yet arrived. ID must stall.
- ms_csr  out  1  valid CSR read or write in MEM.
- ms_ex  out  1  valid with ex_cause≠0 or ertn. EX must suppress new store requests.

Behaviour:
- Registers and reset:
  - ms_valid, ms_bus_r, data_buf_valid, data_buf, cancel_cnt[1:0].
  - On reset low: ms_valid=0, data_buf_valid=0, cancel_cnt=0. All outputs derived from ms_valid go 0.
- Handshake:
  - ms_ready_go = !mem_req | data_buf_valid | (data_sram_data_ok & cancel_cnt==0).
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & !ws_reflush_ms.
  - On ms_allowin, ms_valid <= es_to_ms_valid, and the bus is latched when es_to_ms_valid.
- Flush:
  - ws_reflush_ms forces ms_valid <= 0 and takes priority over acceptance.
  - If the flushed instruction had mem_req and no response consumed (no data_buf_valid, no data_ok that cycle), cancel_cnt increments.
- Cancellation:
  - While cancel_cnt≠0, each data_sram_data_ok decrements cancel_cnt and is ignored by data_buf.
  - cancel_cnt saturates at 3. Reaching 3 is a design error, flagged by a simulation assertion.
  - Simultaneous flush-increment and cancel-decrement leave cancel_cnt unchanged.
- Data buffer:
  - If data_ok arrives with cancel_cnt==0, ms_valid, mem_req and ms_to_ws not accepted that cycle: data_buf <= rdata and data_buf_valid <= 1.
  - data_buf_valid clears on handoff to WB, on flush, or on reset.
- Latency: a load completes in the same cycle as data_ok (zero added cycles). Non-memory instructions pass in 1 cycle.
- Load extraction:
  - Uses addr = final_result[1:0] and data = data_buf_valid ? data_buf : rdata.
  - b/bu: byte at addr, sign-/zero-extended.
  - h/hu: halfword at addr[1], sign-/zero-extended.
  - w: the full 32-bit data.
  - Stores pass final_result unchanged.
- Output bus: ms_to_ws_bus is the latched [168:0] with final_result replaced by the load result when any ld_op bit is set.
- Exceptions: ex_cause≠0 entries never carry mem_req (EX gates this). They pass through unchanged.
- ms_ld_block = ms_valid & |ld_op & !ms_ready_go.

Decomposition:
- Shared package cpu_defs: bus widths (ES_BUS_W, MS_BUS_W), bus field bit offsets, ld_op bit positions.
- One natural sub-module: load_align. It is combinational: addr[1:0], ld_op, raw data in; extended result out.

Test Plan:
- ld.w, addr 0x1000, data_ok 2 cycles after entry with rdata 0x8899AABB → ms_ready_go low for 2 cycles, ms_ld_block=1, then WB receives final_result 0x8899AABB and ms_ld_block drops.
- ld.b at addr 0x1003 with rdata 0x80112233 → 0xFFFFFF80. ld.bu same → 0x00000080. ld.h at addr 0x1002 → 0xFFFF8011. ld.hu → 0x00008011.
- Load in MEM with no response, ws_reflush_ms pulsed → ms_valid=0 next cycle and cancel_cnt=1. The next data_ok (rdata 0xDEAD) is dropped, cancel_cnt=0, and the following load in MEM receives the next response.
- data_ok arrives while ws_allowin=0 → data_buf captures it. When ws_allowin returns, the instruction is handed off with the buffered value and the bus is unchanged.
- ALU instruction with dest=5, result 0x42 → ms_to_ds_dest=5 and ms_to_ds_value=0x42 in the same cycle. The bus is unchanged at WB one cycle later.
- reset asserted low mid-load, with a request outstanding → ms_to_ws_valid, ms_ld_block and ms_ex drop to 0 immediately, and cancel_cnt=0.
